exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage.sv | 87 ++++++++
 tb/tb_exe_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage with single-cycle ALU, branch resolution,
// and a 32-iteration shift-add multiplier that stalls the front of the pipe.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        wb_en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  br,
    input  logic [3:0]  execute_command,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [31:0] imm,
    input  logic [31:0] dest,
    output logic [31:0] alu_result,
    output logic        wb_en_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [31:0] st_val,
    output logic [31:0] dest_out,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] prod, mcand, mplier, alu_comb;
    logic        is_mul, branch, pass;
    assign is_mul = execute_command == 4'b1010;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (is_mul ? BUSY : IDLE) :
                   state == BUSY ? (cnt == 5'd31 ? DONE : BUSY) : IDLE;
    end
    // Operands are latched on entry so input changes during BUSY cannot disturb the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == IDLE && is_mul) begin
            cnt    <= '0;
            prod   <= '0;
            mcand  <= reg1;
            mplier <= reg2;
        end else if (state == BUSY) begin
            prod   <= mplier[0] ? prod + mcand : prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end
    always_comb begin
        case (execute_command)
            4'b0001: alu_comb = reg1 + reg2;
            4'b0010: alu_comb = reg1 - reg2;
            4'b0011: alu_comb = reg1 & reg2;
            4'b0100: alu_comb = reg1 | reg2;
            4'b0101: alu_comb = ~(reg1 | reg2);
            4'b0110: alu_comb = reg1 ^ reg2;
            4'b0111: alu_comb = reg1 << reg2[4:0];
            4'b1000: alu_comb = 32'($signed(reg1) >>> reg2[4:0]);
            4'b1001: alu_comb = reg1 >> reg2[4:0];
            default: alu_comb = '0;
        endcase
    end
    assign branch = br == 2'b11 || (br == 2'b01 && reg1 == '0) || (br == 2'b10 && reg1 != reg2);
    // Reset forces a bubble even while a MUL command sits at the inputs.
    always_comb begin
        stall         = !rst && ((state == IDLE && is_mul) || state == BUSY);
        pass          = !rst && !stall;
        alu_result    = state == DONE ? prod : alu_comb;
        wb_en_out     = pass && wb_en;
        mem_read_out  = pass && mem_read;
        mem_write_out = pass && mem_write;
        br_taken      = pass && branch;
        br_addr       = pc_in + (imm << 2);
        st_val        = reg2;
        dest_out      = dest;
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: random and directed stimulus for exe_stage, checked every
// cycle against a cycle-count reference model plus literal expectations.
module tb_exe_stage;
    logic        clk = 0, rst = 1;
    logic [31:0] pc_in = 0, reg1 = 0, reg2 = 0, imm = 0, dest = 0;
    logic        wb_en = 0, mem_read = 0, mem_write = 0;
    logic [1:0]  br = 0;
    logic [3:0]  execute_command = 0;
    logic [31:0] alu_result, st_val, dest_out, br_addr;
    logic        wb_en_out, mem_read_out, mem_write_out, br_taken, stall;
    int checks = 0, errors = 0;
    bit done_tb = 0;
    int  mcyc = 0;
    logic [31:0] mprod = 0;

    exe_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en(wb_en), .mem_read(mem_read),
        .mem_write(mem_write), .br(br), .execute_command(execute_command),
        .reg1(reg1), .reg2(reg2), .imm(imm), .dest(dest), .alu_result(alu_result),
        .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .st_val(st_val), .dest_out(dest_out), .br_taken(br_taken), .br_addr(br_addr),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b % 32);
        case (c)
            1: return a + b;
            2: return a - b;
            3: return a & b;
            4: return a | b;
            5: return ~(a | b);
            6: return a ^ b;
            7: return a << sh;
            8: return 32'($signed(a) >>> sh);
            9: return a >> sh;
            10: return a * b;
            default: return 0;
        endcase
    endfunction

    // Model: mcyc counts cycles since the MUL was accepted; 1..32 busy, 33 result cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) mcyc <= 0;
        else if (mcyc == 0 && execute_command == 4'd10) begin
            mcyc  <= 1;
            mprod <= reg1 * reg2;
        end else if (mcyc == 33) mcyc <= 0;
        else if (mcyc != 0) mcyc <= mcyc + 1;
    end

    always @(negedge clk) begin
        if (!done_tb) begin
            logic es, g, eb;
            es = !rst && ((mcyc == 0 && execute_command == 4'd10) || (mcyc >= 1 && mcyc <= 32));
            g  = !rst && !es;
            eb = br == 3 || (br == 1 && reg1 == 0) || (br == 2 && reg1 != reg2);
            chk("stall", {31'b0, stall}, {31'b0, es});
            chk("wb_en_out", {31'b0, wb_en_out}, {31'b0, g && wb_en});
            chk("mem_read_out", {31'b0, mem_read_out}, {31'b0, g && mem_read});
            chk("mem_write_out", {31'b0, mem_write_out}, {31'b0, g && mem_write});
            chk("br_taken", {31'b0, br_taken}, {31'b0, g && eb});
            chk("br_addr", br_addr, pc_in + imm * 4);
            chk("st_val", st_val, reg2);
            chk("dest_out", dest_out, dest);
            if (g) chk("alu_result", alu_result, mcyc == 33 ? mprod : alu_ref(execute_command, reg1, reg2));
        end
    end

    task automatic count_stall(input bit tog, output int n);
        n = 0;
        @(negedge clk);
        while (stall && n < 100) begin
            n++;
            chk("bubble_wb", {31'b0, wb_en_out}, 32'd0);
            @(posedge clk); #1;
            if (tog) begin
                reg1 = $urandom; reg2 = $urandom; execute_command = 4'($urandom);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        wb_en = 1; execute_command = 4'd10; reg1 = 7; reg2 = 6;
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_wb", {31'b0, wb_en_out}, 32'd0);
        @(posedge clk); #1;
        execute_command = 0;
        @(posedge clk); #1;
        rst = 0;
        execute_command = 4'd1; reg1 = 32'hFFFFFFFF; reg2 = 1;
        @(negedge clk);
        chk("add_wrap", alu_result, 32'h0);
        chk("add_stall", {31'b0, stall}, 32'd0);
        chk("add_wb", {31'b0, wb_en_out}, 32'd1);
        @(posedge clk); #1;
        execute_command = 4'd8; reg1 = 32'h80000000; reg2 = 32'h24;
        @(negedge clk);
        chk("sra", alu_result, 32'hF8000000);
        @(posedge clk); #1;
        execute_command = 4'd9;
        @(negedge clk);
        chk("srl", alu_result, 32'h08000000);
        @(posedge clk); #1;
        execute_command = 4'd10; reg1 = 7; reg2 = 6;
        count_stall(0, n);
        chk("mul_stalls", n, 33);
        chk("mul_42", alu_result, 42);
        chk("mul_wb", {31'b0, wb_en_out}, 32'd1);
        @(posedge clk); #1;
        execute_command = 0;
        @(posedge clk); #1;
        execute_command = 4'd10; reg1 = 32'hFFFFFFFF; reg2 = 3;
        count_stall(1, n);
        chk("mul_neg_stalls", n, 33);
        chk("mul_neg", alu_result, 32'hFFFFFFFD);
        @(posedge clk); #1;
        execute_command = 0; br = 2'b10; reg1 = 5; reg2 = 5; pc_in = 32'h100; imm = 32'hFFFFFFFE;
        @(negedge clk);
        chk("bne_eq", {31'b0, br_taken}, 32'd0);
        chk("br_addr_lit", br_addr, 32'hF8);
        @(posedge clk); #1;
        reg2 = 6;
        @(negedge clk);
        chk("bne_ne", {31'b0, br_taken}, 32'd1);
        @(posedge clk); #1;
        br = 0; execute_command = 4'd10; reg1 = 123; reg2 = 456;
        repeat (11) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_wb", {31'b0, wb_en_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        count_stall(0, n);
        chk("restart_stalls", n, 33);
        chk("restart_prod", alu_result, 32'd56088);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = $urandom_range(0, 199) == 0;
            pc_in = $urandom; imm = $urandom; dest = $urandom;
            wb_en = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            br = 2'($urandom);
            reg1 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
            reg2 = $urandom_range(0, 3) == 0 ? reg1 : $urandom;
            execute_command = $urandom_range(0, 9) == 0 ? 4'd10 : 4'($urandom);
            if (execute_command == 4'd10 && $urandom_range(0, 1) == 0) execute_command = 4'd1;
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        done_tb = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
